// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer: command front end for a set/reset latch.
// Each raw button is synchronized and then debounced. Every accepted press
// becomes a fixed-width pulse on s or r. s and r are never high together.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   set_btn    raw set button (asynchronous, may bounce)
//   reset_btn  raw reset button (asynchronous, may bounce)
//   s          registered set command to the latch
//   r          registered reset command to the latch
//   busy       registered, high whenever the FSM is not IDLE
//   conflict   registered one-cycle flag: set and reset accepted together
//
// Build option:
//   SR_SET_PRIORITY_EN  when defined, a simultaneous set+reset request
//                       drives s. When undefined, it drives r.

module sr_cmd_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_WIDTH     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic reset_btn,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW_W  = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW_W-1:0]  PW_LOAD = PW_W'(PULSE_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PULSE        = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_e;

    // Channel index 0 is set, index 1 is reset.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            level_q, level_d;
    logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]            req_q, req_d;
    state_e                state_q, state_d;
    logic [PW_W-1:0]       pcnt_q, pcnt_d;
    logic                  sel_set_q, sel_set_d;
    logic                  s_q, s_d;
    logic                  r_q, r_d;
    logic                  busy_q, busy_d;
    logic                  conflict_q, conflict_d;

    // Two-flop synchronizer, debounce counters and rising-edge requests.
    always_comb begin
        sync1_d  = {reset_btn, set_btn};
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == CNT_MAX) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // The request is taken from the next level, so it is registered
        // together with the level change and no extra cycle is added.
        req_d = level_d & ~level_q;
    end

    // Command FSM next state and registered outputs.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        sel_set_d  = sel_set_q;
        conflict_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_q != 2'b00) begin
                    state_d = ST_PULSE;
                    pcnt_d  = PW_LOAD;
                    if (req_q == 2'b11) begin
                        conflict_d = 1'b1;
`ifdef SR_SET_PRIORITY_EN
                        sel_set_d  = 1'b1;
`else
                        sel_set_d  = 1'b0;
`endif
                    end else begin
                        sel_set_d = req_q[0];
                    end
                end
            end
            ST_PULSE: begin
                if (pcnt_q == '0) begin
                    state_d = ST_WAIT_RELEASE;
                end else begin
                    pcnt_d = pcnt_q - PW_W'(1);
                end
            end
            ST_WAIT_RELEASE: begin
                // Requests seen here are dropped; both buttons must release.
                if (level_q == 2'b00) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // s and r both come from a single select bit, so they are exclusive.
        s_d    = (state_d == ST_PULSE) &&  sel_set_d;
        r_d    = (state_d == ST_PULSE) && !sel_set_d;
        busy_d = (state_d != ST_IDLE);
    end

    // All state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            db_cnt_q   <= '0;
            req_q      <= '0;
            state_q    <= ST_IDLE;
            pcnt_q     <= '0;
            sel_set_q  <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            req_q      <= req_d;
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            sel_set_q  <= sel_set_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Directed bench for sr_cmd_debouncer with default parameters.
module tb_sr_cmd_debouncer;

    logic clk;
    logic rst_n;
    logic set_btn;
    logic reset_btn;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    int checks = 0;
    int errors = 0;

`ifdef SR_SET_PRIORITY_EN
    localparam logic SETPRI = 1'b1;
`else
    localparam logic SETPRI = 1'b0;
`endif

    sr_cmd_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_WIDTH    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_btn  (set_btn),
        .reset_btn(reset_btn),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .conflict (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // s and r must never be high together.
    always @(negedge clk) begin
        checks++;
        assert (!(s === 1'b1 && r === 1'b1)) else begin
            errors++;
            $error("FAIL s_and_r observed s=%0b r=%0b expected not both 1", s, r);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic es, input logic er,
                           input logic eb, input logic ec);
        chk({tag, ".s"}, s, es);
        chk({tag, ".r"}, r, er);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".conflict"}, conflict, ec);
    endtask

    initial begin
        rst_n     = 1'b0;
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        #2;
        chk_all("reset0", 0, 0, 0, 0);
        step(3);
        chk_all("reset1", 0, 0, 0, 0);
        rst_n = 1'b1;
        step(3);
        chk_all("idle", 0, 0, 0, 0);

        // Set press held for about 40 cycles: exactly one s pulse.
        set_btn = 1'b1;
        step(6);
        chk_all("set_e5", 0, 0, 0, 0);
        step(1);
        chk_all("set_e6", 1, 0, 1, 0);
        step(1);
        chk_all("set_e7", 1, 0, 1, 0);
        step(1);
        chk_all("set_e8", 0, 0, 1, 0);
        for (int k = 0; k < 31; k++) begin
            step(1);
            chk("set_hold.s", s, 1'b0);
            chk("set_hold.busy", busy, 1'b1);
        end
        set_btn = 1'b0;
        step(6);
        chk_all("set_rel_e5", 0, 0, 1, 0);
        step(1);
        chk_all("set_rel_e6", 0, 0, 0, 0);

        // Reset press: one r pulse.
        reset_btn = 1'b1;
        step(6);
        chk_all("rst_e5", 0, 0, 0, 0);
        step(1);
        chk_all("rst_e6", 0, 1, 1, 0);
        step(1);
        chk_all("rst_e7", 0, 1, 1, 0);
        step(1);
        chk_all("rst_e8", 0, 0, 1, 0);
        reset_btn = 1'b0;
        step(8);
        chk_all("rst_done", 0, 0, 0, 0);

        // Three-cycle glitch must be ignored.
        set_btn = 1'b1;
        step(3);
        set_btn = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk_all("glitch", 0, 0, 0, 0);
        end

        // Simultaneous press: priority pulse plus one-cycle conflict.
        set_btn   = 1'b1;
        reset_btn = 1'b1;
        step(6);
        chk_all("both_e5", 0, 0, 0, 0);
        step(1);
        chk_all("both_e6", SETPRI, ~SETPRI, 1, 1);
        step(1);
        chk_all("both_e7", SETPRI, ~SETPRI, 1, 0);
        step(1);
        chk_all("both_e8", 0, 0, 1, 0);
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        step(8);
        chk_all("both_done", 0, 0, 0, 0);

        // Reset request during WAIT_RELEASE is dropped.
        set_btn = 1'b1;
        step(9);
        chk_all("wr_e8", 0, 0, 1, 0);
        reset_btn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(1);
            chk_all("wr_drop", 0, 0, 1, 0);
        end
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        step(8);
        chk_all("wr_done", 0, 0, 0, 0);

        // rst_n during the s pulse, button still held afterwards.
        set_btn = 1'b1;
        step(7);
        chk_all("mid_e6", 1, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        chk_all("mid_async", 0, 0, 0, 0);
        step(2);
        chk_all("mid_held", 0, 0, 0, 0);
        rst_n = 1'b1;
        step(6);
        chk_all("again_e5", 0, 0, 0, 0);
        step(1);
        chk_all("again_e6", 1, 0, 1, 0);
        step(1);
        chk_all("again_e7", 1, 0, 1, 0);
        step(1);
        chk_all("again_e8", 0, 0, 1, 0);
        set_btn = 1'b0;
        step(8);
        chk_all("again_done", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
